// File: rtl/serial_add_pkg.sv
// Shared types for the nibble-serial adder/subtractor.
// Holds the sequencer state enum and the slice width.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of adder-slice passes for a given operand width.
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_adder_slice.sv
// One 4-bit ripple adder slice: s = a + b + cin.
// Ports: a, b (4b), cin -> s (4b), cout, c_msb_in (carry into bit 3).
module nibble_adder_slice
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c_msb_in
);

  logic [NIBBLE_W-1:0] low;
  logic [1:0]          hi;

  // Lower three bits first so the carry into the MSB is visible;
  // the sequencer needs it for signed overflow on the last slice.
  assign low = {1'b0, a[NIBBLE_W-2:0]}
             + {1'b0, b[NIBBLE_W-2:0]}
             + {{(NIBBLE_W-1){1'b0}}, cin};

  assign c_msb_in = low[NIBBLE_W-1];

  assign hi = {1'b0, a[NIBBLE_W-1]}
            + {1'b0, b[NIBBLE_W-1]}
            + {1'b0, c_msb_in};

  assign s    = {hi[0], low[NIBBLE_W-2:0]};
  assign cout = hi[1];

endmodule

// File: rtl/serial_add_sequencer.sv
// Nibble-serial add/subtract: WIDTH/4 slice passes, LSB first.
// Ports: clk, rst_n; in_valid/in_ready, a, b, cin, sub;
//        out_valid/out_ready, sum, cout, ovf.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBS  = nib_count(WIDTH);
  localparam int IDX_W = $clog2(NIBS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               c_q, c_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] s_nib;
  logic                s_cout;
  logic                s_cmsb;

  assign a_nib = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

  nibble_adder_slice u_slice (
    .a        (a_nib),
    .b        (b_nib),
    .cin      (c_q),
    .s        (s_nib),
    .cout     (s_cout),
    .c_msb_in (s_cmsb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (in_valid) begin
          // Subtract as a + ~b + 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = cin | sub;
          idx_d   = '0;
          // Unwritten nibbles read as zero while running.
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        sum_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = s_nib;
        c_d   = s_cout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = s_cout;
          ovf_d   = s_cout ^ s_cmsb;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      (state_q == DONE): begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed + random bench for serial_add_sequencer.
// Expected results queue up at issue and are popped at delivery.
module tb_serial_add_sequencer;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic ci,
                                 input logic sb);
    res_t r;
    logic [W-1:0] yy;
    logic [W:0]   full;
    yy   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb | ci)};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == yy[W-1]) && (r.sum[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic send(input logic [W-1:0] x,
                      input logic [W-1:0] y,
                      input logic ci,
                      input logic sb);
    a = x; b = y; cin = ci; sub = sb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("busy_in_ready", 64'(in_ready), 64'd0);
  endtask

  // Wait for a result, optionally stall it, then compare and release.
  task automatic collect(input int hold, input bit chk_lat);
    res_t e;
    int   lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    if (chk_lat) chk("latency", 64'(lat), 64'd5);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sum", 64'(sum), 64'(e.sum));
      tick();
    end
    chk("sum", 64'(sum), 64'(e.sum));
    chk("cout", 64'(cout), 64'(e.cout));
    chk("ovf", 64'(ovf), 64'(e.ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("back_idle", 64'(in_ready), 64'd1);
    chk("valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    tick();

    exp_q.push_back('{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    collect(0, 1'b1);

    exp_q.push_back('{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    collect(0, 1'b1);

    exp_q.push_back('{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0});
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    collect(0, 1'b1);

    exp_q.push_back('{sum: 16'h2346, cout: 1'b0, ovf: 1'b0});
    send(16'h1234, 16'h1111, 1'b1, 1'b0);
    collect(3, 1'b1);

    // Request held high across a busy period.
    a = 16'h0100; b = 16'h0022; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    exp_q.push_back('{sum: 16'h0122, cout: 1'b0, ovf: 1'b0});
    tick();
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
    tick();
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    tick();
    a = 16'h8000; b = 16'h8000; cin = 1'b1; sub = 1'b0;
    exp_q.push_back('{sum: 16'h0001, cout: 1'b1, ovf: 1'b1});
    collect(0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("second_accept", 64'(in_ready), 64'd0);
    collect(0, 1'b1);

    // Abort mid-operation.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    tick();
    chk("partial_sum", 64'(sum), 64'h0033);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      exp_q.push_back(model(ra, rb, rc, rs));
      send(ra, rb, rc, rs);
      collect(i % 3, 1'b1);
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
